// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life board engine.
package life_pkg;

    localparam int LIFE_ROWS  = 15;
    localparam int LIFE_COLS  = 20;
    localparam int LIFE_GEN_W = 16;

    typedef logic [LIFE_COLS-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } state_e;

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation rule for one board row given its neighbour rows.
module life_row_next
    import life_pkg::*;
#(
    parameter int COLS = LIFE_COLS
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next
);

    // One dead guard column on each side; cell c sits at padded index c+1.
    logic [COLS+1:0] a_p, c_p, b_p;

    assign a_p = {1'b0, above, 1'b0};
    assign c_p = {1'b0, cur,   1'b0};
    assign b_p = {1'b0, below, 1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        logic [3:0] cnt;

        assign cnt = 4'(a_p[c]) + 4'(a_p[c+1]) + 4'(a_p[c+2])
                   + 4'(c_p[c])                + 4'(c_p[c+2])
                   + 4'(b_p[c]) + 4'(b_p[c+1]) + 4'(b_p[c+2]);

        assign next[c] = (cnt == 4'd3) | (cur[c] & (cnt == 4'd2));
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life board: row-serial next-generation into a shadow buffer, atomic commit,
// combinational display read port and an IDLE-only row-load port.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = LIFE_ROWS,
    parameter int COLS  = LIFE_COLS,
    parameter int GEN_W = LIFE_GEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load_en,
    input  logic [3:0]       load_row,
    input  logic [COLS-1:0]  load_data,
    input  logic [3:0]       rd_row,
    input  logic [4:0]       rd_col,
    output logic             rd_cell,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic [3:0] ROW_LIM  = 4'(ROWS);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [4:0] COL_LIM  = 5'(COLS);

    state_e                      state;
    logic [3:0]                  row_idx;
    logic [ROWS-1:0][COLS-1:0]   board;
    logic [ROWS-1:0][COLS-1:0]   shadow;
    logic [COLS-1:0]             above, cur, below, nxt;

    // Rows outside the board read as all-dead.
    always_comb begin
        above = '0;
        below = '0;
        cur   = board[row_idx];
        if (row_idx != 4'd0)
            above = board[row_idx - 4'd1];
        if (row_idx != LAST_ROW)
            below = board[row_idx + 4'd1];
    end

    life_row_next #(.COLS(COLS)) u_row_next (
        .above (above),
        .cur   (cur),
        .below (below),
        .next  (nxt)
    );

    always_comb begin
        rd_cell = 1'b0;
        if (rd_row < ROW_LIM && rd_col < COL_LIM)
            rd_cell = board[rd_row][rd_col];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            board     <= '0;
            shadow    <= '0;
            gen_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Load wins over step when both arrive together.
                    if (load_en) begin
                        if (load_row < ROW_LIM)
                            board[load_row] <= load_data;
                    end else if (step) begin
                        row_idx <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    shadow[row_idx] <= nxt;
                    if (row_idx == LAST_ROW)
                        state <= COMMIT;
                    else
                        row_idx <= row_idx + 4'd1;
                end
                COMMIT: begin
                    board     <= shadow;
                    gen_count <= gen_count + 1'b1;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
